// File: rtl/mem_bus_bridge.sv
// Memory-stage bridge: turns one M-stage load/store into a single split-transaction bus access.
// Stalls the pipeline until the response arrives or the access times out; outputs registered except stallM_o.
module mem_bus_bridge #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [3:0]  selectM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        hold_i,
  input  logic        flushM,
  output logic [31:0] readdataM,
  output logic        stallM_o,
  output logic        err_o,
  output logic        req,
  output logic        wr,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_req;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [15:0] r_cnt;
  logic        r_retire;

  logic        w_start;
  logic        w_busy;
  logic        w_tout;
  logic        w_cap;
  logic        w_fire;
  logic        w_fire_drain;
  logic        w_unused;

  // Byte offset is carried by the strobes, so the low address bits are dropped.
  assign w_unused = &{1'b0, aluoutM[1:0]};

  // r_retire suppresses a new request for the one cycle a timed-out access retires.
  assign w_start = (r_state == S_IDLE) & memenM & ~flushM & ~r_retire;
  assign w_busy  = (r_state == S_REQ) | (r_state == S_WAIT) | (r_state == S_DRAIN);
  assign w_tout  = w_busy & (r_cnt == TO_LAST);

  assign stallM_o = w_start | w_busy;

  always_comb begin
    w_next       = r_state;
    w_cap        = 1'b0;
    w_fire       = 1'b0;
    w_fire_drain = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_REQ;
      end
      S_REQ: begin
        if (addr_ok) begin
          if (flushM) begin
            w_next = data_ok ? S_IDLE : S_DRAIN;
          end else if (data_ok) begin
            w_next = S_DONE;
            w_cap  = ~r_wr;
          end else begin
            w_next = S_WAIT;
          end
        end else if (flushM) begin
          w_next = S_IDLE;
        end else if (w_tout) begin
          w_next = S_IDLE;
          w_fire = 1'b1;
        end
      end
      S_WAIT: begin
        if (data_ok) begin
          w_next = flushM ? S_IDLE : S_DONE;
          w_cap  = ~r_wr & ~flushM;
        end else if (flushM) begin
          w_next = S_DRAIN;
        end else if (w_tout) begin
          w_next = S_IDLE;
          w_fire = 1'b1;
        end
      end
      S_DRAIN: begin
        if (data_ok) begin
          w_next = S_IDLE;
        end else if (w_tout) begin
          w_next       = S_IDLE;
          w_fire_drain = 1'b1;
        end
      end
      S_DONE: begin
        if (!hold_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= 32'd0;
      r_wstrb  <= 4'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      r_cnt    <= 16'd0;
      r_retire <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_retire <= w_fire;

      if (w_start) begin
        r_req   <= 1'b1;
        r_wr    <= memwriteM;
        r_addr  <= {aluoutM[31:2], 2'b00};
        r_wstrb <= memwriteM ? selectM : 4'b0000;
        r_wdata <= writedataM;
      end else if ((r_state == S_REQ) && (w_next != S_REQ)) begin
        r_req <= 1'b0;
      end

      if (w_start) begin
        r_cnt <= 16'd0;
      end else if (w_busy && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end

      // Poison value lets software see a load that never got a response.
      if (w_cap) begin
        r_rdata <= rdata;
      end else if (w_fire && !r_wr) begin
        r_rdata <= 32'hDEADBEEF;
      end

      if (w_fire || w_fire_drain) r_err <= 1'b1;
    end
  end

  assign req       = r_req;
  assign wr        = r_wr;
  assign addr      = r_addr;
  assign wstrb     = r_wstrb;
  assign wdata     = r_wdata;
  assign readdataM = r_rdata;
  assign err_o     = r_err;

endmodule
